// File: rtl/exu_wb_buffer_pkg.sv
// Shared widths, packed writeback record layout and occupancy encoding for the
// execute-to-writeback buffer.
package exu_wb_buffer_pkg;

  localparam int XLEN       = 64;
  localparam int REG_IDX_W  = 5;
  localparam int WB_ENTRY_W = XLEN + REG_IDX_W + 1 + XLEN;

  // Field offsets inside the packed entry (pc occupies the low bits).
  localparam int WB_PC_LSB   = 0;
  localparam int WB_WEN_BIT  = XLEN;
  localparam int WB_RD_LSB   = XLEN + 1;
  localparam int WB_DATA_LSB = XLEN + 1 + REG_IDX_W;

  typedef struct packed {
    logic [XLEN-1:0]      data;
    logic [REG_IDX_W-1:0] rd;
    logic                 wen;
    logic [XLEN-1:0]      pc;
  } wb_entry_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  // RV64 W-suffix ops write back the sign-extended low word.
  function automatic logic [XLEN-1:0] word_sext(input logic [XLEN-1:0] v,
                                                input logic            word);
    return word ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
  endfunction

endpackage

// File: rtl/wb_fifo2.sv
// Generic two-entry FIFO with registered ready/valid on both sides; ready and
// valid depend only on the occupancy register, never on the opposite port.
module wb_fifo2
  import exu_wb_buffer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output occ_e             occ_o
);

  // Handshake: a transfer happens on a rising edge where valid && ready;
  // valid never waits on ready, and data is held stable while valid && !ready.

  logic [WIDTH-1:0] mem_q [2];
  occ_e             occ_q, occ_d;
  logic             head_q, head_d;
  logic             tail_q, tail_d;
  logic             push, pop;

  assign in_ready  = (occ_q != OCC_FULL);
  assign out_valid = (occ_q != OCC_EMPTY);
  assign out_data  = mem_q[head_q];
  assign occ_o     = occ_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    if (flush) begin
      occ_d  = OCC_EMPTY;
      head_d = 1'b0;
      tail_d = 1'b0;
    end else begin
      if (push) tail_d = ~tail_q;
      if (pop)  head_d = ~head_q;
      unique case (occ_q)
        OCC_EMPTY: if (push) occ_d = OCC_ONE;
        OCC_ONE: begin
          if (push && !pop)      occ_d = OCC_FULL;
          else if (pop && !push) occ_d = OCC_EMPTY;
        end
        OCC_FULL:  if (pop) occ_d = OCC_ONE;
        default:   occ_d = OCC_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q  <= OCC_EMPTY;
      head_q <= 1'b0;
      tail_q <= 1'b0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // A flushed cycle drops the offered record, so the write is suppressed too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
    end else if (push && !flush) begin
      mem_q[tail_q] <= in_data;
    end
  end

endmodule

// File: rtl/exu_wb_buffer.sv
// Execute-to-writeback elastic buffer: formats the ALU result (word sign
// extension, x0 write suppression) and queues it in a two-entry FIFO.
module exu_wb_buffer
  import exu_wb_buffer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [XLEN-1:0]      alu_result,
  input  logic [REG_IDX_W-1:0] in_rd,
  input  logic                 in_wen,
  input  logic                 in_word,
  input  logic [XLEN-1:0]      in_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      wb_data,
  output logic [REG_IDX_W-1:0] wb_rd,
  output logic                 wb_wen,
  output logic [XLEN-1:0]      wb_pc,
  output occ_e                 occ_dbg
);

  wb_entry_t              in_entry;
  wb_entry_t              head_entry;
  logic [WB_ENTRY_W-1:0]  head_bits;

  always_comb begin
    in_entry      = '0;
    in_entry.data = word_sext(alu_result, in_word);
    in_entry.rd   = in_rd;
    in_entry.wen  = in_wen && (in_rd != '0);
    in_entry.pc   = in_pc;
  end

  wb_fifo2 #(
    .WIDTH(WB_ENTRY_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_entry),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (head_bits),
    .occ_o    (occ_dbg)
  );

  assign head_entry = wb_entry_t'(head_bits);
  assign wb_data    = head_entry.data;
  assign wb_rd      = head_entry.rd;
  // Stale entries may hold wen=1 after a pop or flush; never expose that.
  assign wb_wen     = out_valid && head_entry.wen;
  assign wb_pc      = head_entry.pc;

endmodule

// File: tb/tb_exu_wb_buffer.sv
// Self-checking bench for exu_wb_buffer: queue-based reference model checked
// every cycle, plus directed scenarios with literal expected values.
module tb_exu_wb_buffer;

  typedef struct packed {
    logic [63:0] data;
    logic [4:0]  rd;
    logic        wen;
    logic [63:0] pc;
  } rec_t;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] alu_result;
  logic [4:0]  in_rd;
  logic        in_wen;
  logic        in_word;
  logic [63:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_wen;
  logic [63:0] wb_pc;
  logic [1:0]  occ_dbg;

  int checks   = 0;
  int failures = 0;

  rec_t exp_q[$];

  exu_wb_buffer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_result(alu_result),
    .in_rd     (in_rd),
    .in_wen    (in_wen),
    .in_word   (in_word),
    .in_pc     (in_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .wb_data   (wb_data),
    .wb_rd     (wb_rd),
    .wb_wen    (wb_wen),
    .wb_pc     (wb_pc),
    .occ_dbg   (occ_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] alu, input logic [4:0] rd,
                       input logic wen, input logic word, input logic [63:0] pc);
    in_valid   = v;
    alu_result = alu;
    in_rd      = rd;
    in_wen     = wen;
    in_word    = word;
    in_pc      = pc;
  endtask

  task automatic idle();
    drive(1'b0, 64'd0, 5'd0, 1'b0, 1'b0, 64'd0);
  endtask

  // ---------------- reference model ----------------
  function automatic rec_t make_rec(input logic [63:0] alu, input logic [4:0] rd,
                                    input logic wen, input logic word, input logic [63:0] pc);
    rec_t r;
    logic signed [31:0] lo;
    lo     = alu[31:0];
    r.data = word ? 64'(longint'(lo)) : alu;
    r.rd   = rd;
    r.wen  = wen && (rd != 5'd0);
    r.pc   = pc;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      bit do_push, do_pop;
      rec_t r;
      do_push = in_valid && (exp_q.size() < 2);
      do_pop  = out_ready && (exp_q.size() > 0);
      r = make_rec(alu_result, in_rd, in_wen, in_word, in_pc);
      if (flush) begin
        exp_q.delete();
      end else begin
        if (do_pop)  void'(exp_q.pop_front());
        if (do_push) exp_q.push_back(r);
      end
    end
  end

  // ---------------- scoreboard compare (every cycle) ----------------
  always @(negedge clk) begin
    chk("sb_out_valid", {63'd0, out_valid}, {63'd0, exp_q.size() != 0});
    chk("sb_in_ready",  {63'd0, in_ready},  {63'd0, exp_q.size() != 2});
    chk("sb_occupancy", {62'd0, occ_dbg},   64'(exp_q.size()));
    if (exp_q.size() != 0) begin
      chk("sb_wb_data", wb_data, exp_q[0].data);
      chk("sb_wb_rd",   {59'd0, wb_rd}, {59'd0, exp_q[0].rd});
      chk("sb_wb_wen",  {63'd0, wb_wen}, {63'd0, exp_q[0].wen});
      chk("sb_wb_pc",   wb_pc, exp_q[0].pc);
    end else begin
      chk("sb_wb_wen_empty", {63'd0, wb_wen}, 64'd0);
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    idle();
    repeat (2) step();

    // Reset state
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
    chk("rst_wb_data",   wb_data, 64'd0);
    chk("rst_wb_rd",     {59'd0, wb_rd}, 64'd0);
    chk("rst_wb_wen",    {63'd0, wb_wen}, 64'd0);
    chk("rst_wb_pc",     wb_pc, 64'd0);
    rst_n = 1'b1;
    step();

    // Word op sign extension, one-cycle latency
    drive(1'b1, 64'h0000_0000_8000_0001, 5'd5, 1'b1, 1'b1, 64'h100);
    step();
    idle();
    chk("word_out_valid", {63'd0, out_valid}, 64'd1);
    chk("word_wb_data",   wb_data, 64'hFFFF_FFFF_8000_0001);
    chk("word_wb_rd",     {59'd0, wb_rd}, 64'd5);
    chk("word_wb_wen",    {63'd0, wb_wen}, 64'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("word_drained", {63'd0, out_valid}, 64'd0);

    // x0 write suppression
    drive(1'b1, 64'h1234, 5'd0, 1'b1, 1'b0, 64'h104);
    step();
    idle();
    chk("x0_out_valid", {63'd0, out_valid}, 64'd1);
    chk("x0_wb_wen",    {63'd0, wb_wen}, 64'd0);
    chk("x0_wb_data",   wb_data, 64'h1234);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Backpressure: A then B fill the buffer, drain in order
    drive(1'b1, 64'hA, 5'd1, 1'b1, 1'b0, 64'h8000_0000);
    step();
    chk("bp_ready_after_a", {63'd0, in_ready}, 64'd1);
    drive(1'b1, 64'hB, 5'd2, 1'b1, 1'b0, 64'h8000_0004);
    step();
    idle();
    chk("bp_ready_full", {63'd0, in_ready}, 64'd0);
    chk("bp_head_a",     wb_pc, 64'h8000_0000);
    step();
    chk("bp_head_a_held", wb_pc, 64'h8000_0000);
    out_ready = 1'b1;
    step();
    chk("bp_head_b",        wb_pc, 64'h8000_0004);
    chk("bp_ready_after_pop", {63'd0, in_ready}, 64'd1);
    step();
    chk("bp_empty", {63'd0, out_valid}, 64'd0);

    // Streaming: 8 back-to-back records, one-cycle latency, ready never low
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 64'(i * 17), 5'(i + 3), 1'b1, 1'b0, 64'h2000 + 64'(4 * i));
      step();
      chk("stream_ready", {63'd0, in_ready}, 64'd1);
      chk("stream_pc",    wb_pc, 64'h2000 + 64'(4 * i));
    end
    idle();
    step();
    chk("stream_empty", {63'd0, out_valid}, 64'd0);

    // Flush while FULL with simultaneous push and pop
    out_ready = 1'b0;
    drive(1'b1, 64'h11, 5'd7, 1'b1, 1'b0, 64'h3000);
    step();
    drive(1'b1, 64'h22, 5'd8, 1'b1, 1'b0, 64'h3004);
    step();
    chk("flush_pre_full", {63'd0, in_ready}, 64'd0);
    drive(1'b1, 64'h33, 5'd9, 1'b1, 1'b0, 64'h3008);
    out_ready = 1'b1;
    flush     = 1'b1;
    step();
    flush = 1'b0;
    idle();
    chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_in_ready",  {63'd0, in_ready}, 64'd1);
    chk("flush_occ",       {62'd0, occ_dbg}, 64'd0);
    step();
    chk("flush_no_emit", {63'd0, out_valid}, 64'd0);

    // Asynchronous reset while holding one record
    out_ready = 1'b0;
    drive(1'b1, 64'h44, 5'd10, 1'b1, 1'b0, 64'h4000);
    step();
    idle();
    chk("areset_pre_valid", {63'd0, out_valid}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("areset_wb_wen",    {63'd0, wb_wen}, 64'd0);
    chk("areset_in_ready",  {63'd0, in_ready}, 64'd1);
    step();
    rst_n = 1'b1;
    drive(1'b1, 64'h55, 5'd11, 1'b1, 1'b0, 64'h5000);
    step();
    idle();
    chk("post_reset_head", wb_pc, 64'h5000);
    out_ready = 1'b1;
    step();

    // Mixed traffic with occasional flush, checked by the scoreboard
    for (int i = 0; i < 200; i++) begin
      drive(1'($urandom_range(0, 1)), {$urandom, $urandom}, 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 64'h6000 + 64'(4 * i));
      out_ready = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 15) == 0);
      step();
    end
    idle();
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    chk("final_empty", {63'd0, out_valid}, 64'd0);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
